// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: rebuilds h/v counters from incoming sync, measures line and
// frame lengths, and tracks lock against the nominal timing.
//
// state      | meaning
// SEARCH     | no frame reference yet, line checks ignored
// ACQUIRE    | counting consecutive good frames toward lock
// LOCKED     | timing confirmed, any bad line/frame or timeout drops lock
module vga_sync_decoder #(
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int H_ACTIVE        = 640,
   parameter int H_FP            = 16,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 10,
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_pix_en,
   input  logic       i_h_sync_in,
   input  logic       i_v_sync_in,
   output logic [9:0] o_h_count,
   output logic [9:0] o_v_count,
   output logic       o_active,
   output logic       o_line_start,
   output logic       o_frame_start,
   output logic [9:0] o_h_total,
   output logic [9:0] o_v_total,
   output logic       o_locked,
   output logic       o_timing_err
);
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int TO_LOAD = 2 * H_TOTAL;
   localparam int TO_W    = $clog2(TO_LOAD + 1);
   localparam int GC_W    = $clog2(LOCK_FRAMES + 1);

   localparam logic [9:0] CNT_MAX  = 10'h3FF;
   localparam logic [9:0] H_TOT_C  = 10'(H_TOTAL);
   localparam logic [9:0] V_TOT_C  = 10'(V_TOTAL);
   localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE);

   typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

   state_t            r_state;
   logic [1:0]        r_h_sync, r_v_sync;
   logic              r_h_prev, r_v_prev, r_v_pend;
   logic [9:0]        r_h_count, r_v_count, r_h_total, r_v_total;
   logic              r_active, r_line_start, r_frame_start, r_locked, r_timing_err;
   logic              r_frame_bad;
   logic [GC_W-1:0]   r_good_cnt;
   logic [TO_W-1:0]   r_to_cnt;

   logic              w_h_pol, w_v_pol, w_h_start, w_v_start, w_frame;
   logic [9:0]        w_h_inc, w_v_inc, w_h_nxt, w_v_nxt;
   logic              w_line_bad, w_vtot_bad, w_timeout, w_frame_good;
   logic              w_err, w_lock_gain, w_lock_nxt, w_act_nxt;

   // Inversion ahead of the synchronizer so everything downstream is active-high
   assign w_h_pol = i_h_sync_in ^ SYNC_ACTIVE_LOW;
   assign w_v_pol = i_v_sync_in ^ SYNC_ACTIVE_LOW;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_h_sync <= 2'b00;
         r_v_sync <= 2'b00;
      end else begin
         r_h_sync <= {r_h_sync[0], w_h_pol};
         r_v_sync <= {r_v_sync[0], w_v_pol};
      end
   end

   assign w_h_start    = i_pix_en & r_h_sync[1] & ~r_h_prev;
   assign w_v_start    = i_pix_en & r_v_sync[1] & ~r_v_prev;
   assign w_frame      = w_h_start & (w_v_start | r_v_pend);
   assign w_h_inc      = (r_h_count == CNT_MAX) ? CNT_MAX : r_h_count + 10'd1;
   assign w_v_inc      = (r_v_count == CNT_MAX) ? CNT_MAX : r_v_count + 10'd1;
   assign w_line_bad   = w_h_start & (w_h_inc != H_TOT_C);
   assign w_vtot_bad   = w_frame & (w_v_inc != V_TOT_C);
   assign w_timeout    = i_pix_en & ~w_h_start & (r_to_cnt == TO_W'(1));
   assign w_frame_good = ~r_frame_bad & ~w_line_bad & ~w_vtot_bad;
   assign w_err        = w_timeout |
                         ((r_state == ST_LOCKED) & (w_line_bad | w_vtot_bad));
   assign w_lock_gain  = (r_state == ST_ACQUIRE) & w_frame & w_frame_good &
                         (r_good_cnt == GC_W'(LOCK_FRAMES - 1));
   assign w_lock_nxt   = (r_locked & ~w_err) | w_lock_gain;

   always_comb begin
      w_h_nxt = r_h_count;
      w_v_nxt = r_v_count;
      if (w_h_start) begin
         w_h_nxt = 10'd0;
         w_v_nxt = w_frame ? 10'd0 : w_v_inc;
      end else if (i_pix_en) begin
         w_h_nxt = w_h_inc;
      end
   end

   assign w_act_nxt = w_lock_nxt &
                      (w_h_nxt >= H_ACT_LO) & (w_h_nxt < H_ACT_HI) &
                      (w_v_nxt >= V_ACT_LO) & (w_v_nxt < V_ACT_HI);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= ST_SEARCH;
         r_h_prev      <= 1'b0;
         r_v_prev      <= 1'b0;
         r_v_pend      <= 1'b0;
         r_h_count     <= 10'd0;
         r_v_count     <= 10'd0;
         r_h_total     <= 10'd0;
         r_v_total     <= 10'd0;
         r_active      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_locked      <= 1'b0;
         r_timing_err  <= 1'b0;
         r_frame_bad   <= 1'b0;
         r_good_cnt    <= '0;
         r_to_cnt      <= '0;
      end else begin
         r_line_start  <= w_h_start;
         r_frame_start <= w_frame;
         r_timing_err  <= w_err;
         r_locked      <= w_lock_nxt;
         r_active      <= w_act_nxt;
         r_h_count     <= w_h_nxt;
         r_v_count     <= w_v_nxt;

         if (i_pix_en) begin
            r_h_prev <= r_h_sync[1];
            r_v_prev <= r_v_sync[1];
         end

         // A vsync start between line starts is held until the next hsync start
         if (w_h_start) begin
            r_h_total <= w_h_inc;
            r_v_pend  <= 1'b0;
            if (w_frame)
               r_v_total <= w_v_inc;
         end else if (w_v_start) begin
            r_v_pend <= 1'b1;
         end

         // Parks at zero after expiry so the timeout fires once per episode
         if (w_h_start)
            r_to_cnt <= TO_W'(TO_LOAD);
         else if (i_pix_en && r_to_cnt != '0)
            r_to_cnt <= r_to_cnt - TO_W'(1);

         if (w_err) begin
            r_state <= ST_SEARCH;
         end else begin
            case (r_state)
               ST_SEARCH: begin
                  if (w_frame) begin
                     r_state     <= ST_ACQUIRE;
                     r_good_cnt  <= '0;
                     r_frame_bad <= 1'b0;
                  end
               end
               ST_ACQUIRE: begin
                  if (w_frame) begin
                     r_frame_bad <= 1'b0;
                     if (w_frame_good) begin
                        r_good_cnt <= r_good_cnt + GC_W'(1);
                        if (w_lock_gain)
                           r_state <= ST_LOCKED;
                     end else begin
                        r_good_cnt <= '0;
                     end
                  end else if (w_line_bad) begin
                     r_frame_bad <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_h_count     = r_h_count;
   assign o_v_count     = r_v_count;
   assign o_active      = r_active;
   assign o_line_start  = r_line_start;
   assign o_frame_start = r_frame_start;
   assign o_h_total     = r_h_total;
   assign o_v_total     = r_v_total;
   assign o_locked      = r_locked;
   assign o_timing_err  = r_timing_err;
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of our VGA timing generator: samples incoming h_sync/v_sync at pixel rate and reconstructs h_count/v_count.
- Measures line and frame lengths, declares lock against the expected 640x480 timing, and flags timing errors.
- Used as a loopback checker on generator outputs and as the front end for any block consuming external VGA-style sync.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (H_TOTAL = sum = 800)
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (V_TOTAL = sum = 525)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low, 0 = high
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_en  in  1  one-clk pixel-rate enable (1 in 4 clks nominal)
- h_sync_in  in  1  incoming horizontal sync
- v_sync_in  in  1  incoming vertical sync
- h_count  out  10  pixel index since last hsync start
- v_count  out  10  line index since last vsync start
- active  out  1  locked and inside visible window
- line_start  out  1  one-clk pulse on detected hsync start
- frame_start  out  1  one-clk pulse on detected vsync start
- h_total  out  10  last measured line length in pixels
- v_total  out  10  last measured frame length in lines
- locked  out  1  timing lock
- timing_err  out  1  one-clk pulse on mismatch or timeout

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state SEARCH; synchronizers cleared to the inactive sync level.
- Sync inputs pass through a 2-flop synchronizer on every clk; if SYNC_ACTIVE_LOW=1 they are inverted to active-high internally.
- Sampling: edge detection compares synchronized values only on pix_en cycles; toggles between enables are invisible.
- Sync start = inactive->active transition between consecutive pix_en samples.
- hsync start (pix_en cycle):
  - h_total <= h_count+1; h_count <= 0; line_start=1.
  - If vsync start was detected on this sample or since the previous hsync start: v_total <= v_count+1, v_count <= 0, frame_start=1.
  - Otherwise v_count <= v_count+1.
- Other pix_en cycles: h_count+1, saturating at 1023. v_count also saturates at 1023. No wrap-around.
- Line check at each hsync start: line bad if h_total != H_TOTAL. Mark frame bad; ignore lines before the first frame_start after SEARCH.
- Timeout: 2*H_TOTAL pix_en cycles without hsync start acts as a bad line and forces SEARCH; timing_err fires once per timeout episode.
- FSM, evaluated at frame_start:
  - SEARCH -> ACQUIRE on first frame_start; good_cnt=0.
  - ACQUIRE: frame good (no bad line and v_total==V_TOTAL) -> good_cnt+1; good_cnt reaching LOCK_FRAMES -> LOCKED, locked=1 on that cycle. Bad frame -> good_cnt=0, stay in ACQUIRE.
  - LOCKED: first bad line, immediately at that hsync start -> timing_err=1 for one clk, locked=0, state SEARCH. Bad v_total at frame_start behaves the same.
- active = locked && H_SYNC+H_BP <= h_count < H_SYNC+H_BP+H_ACTIVE && V_SYNC+V_BP <= v_count < V_SYNC+V_BP+V_ACTIVE, registered with the counters.
- Latency: an input sync edge shows at line_start/frame_start 2 clks plus wait to the next pix_en.
- Simultaneous h/v start: handled as frame start. The counted line is the previous line.
- Mid-frame reset: outputs zero immediately; after release, the decoder relocks from SEARCH.

Test Plan:
- Reset asserted mid-frame with nominal stream -> all outputs 0 within same clk; after release, locked stays 0 until the lock sequence completes.
- Nominal 640x480 stream from generator model, pix_en 1-in-4 -> h_total=800, v_total=525. Locked rises at the frame_start ending the 2nd complete frame after the first frame_start. Active first true at h_count=144, v_count=35; 640*480 active pix_en cycles per frame.
- While locked, one line stretched to 801 pixels -> timing_err pulse and locked=0 at that line's closing hsync start. Relock after 2 further good frames.
- hsync held inactive while locked -> timing_err after 1600 pix_en cycles, single pulse; h_count holds at 1023; locked=0.
- Sync pulse toggled for one clk between pix_en strobes -> no line_start, counters unaffected.
- SYNC_ACTIVE_LOW=0 with inverted-polarity stream -> identical lock timing and counts as the nominal case.
